uart_cmd_parser: RTL and testbench

//  Sits between uartRx and the DTS search core. Turns received bytes into
//  one-cycle command pulses and runtime config registers.

---
 rtl/uart_cmd_parser.sv | 179 +++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// UART command parser: turns received bytes into command pulses, hex-argument
// config registers (thresh/seed) and a one-deep 'K'/'?' ack byte.
module uart_cmd_parser #(
   parameter int               ARG_W        = 32,
   parameter logic [ARG_W-1:0] THRESH_RESET = ARG_W'(200000),
   parameter logic [ARG_W-1:0] SEED_RESET   = ARG_W'(1),
   parameter int               TIMEOUT_CYC  = 300000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   output logic             soft_reset,
   output logic             another,
   output logic [ARG_W-1:0] thresh,
   output logic             thresh_wr,
   output logic [ARG_W-1:0] seed,
   output logic             seed_wr,
   output logic             err,
   output logic             ack_valid,
   output logic [7:0]       ack_byte,
   input  logic             ack_ready,
   output logic [7:0]       last_cmd
);

   localparam int ND  = ARG_W / 4;
   localparam int NDW = $clog2(ND + 1);
   localparam int TW  = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [NDW-1:0] ND_MAX     = NDW'(ND);

   typedef enum logic [1:0] {IDLE, ARG_T, ARG_S} state_t;

   state_t           state_q, state_d;
   logic [ARG_W-1:0] acc_q, acc_d, thresh_q, thresh_d, seed_q, seed_d;
   logic [NDW-1:0]   ndig_q, ndig_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [7:0]       last_cmd_q, last_cmd_d, ack_byte_q, ack_byte_d;
   logic             ack_valid_q, ack_valid_d;
   logic             soft_reset_q, soft_reset_d, another_q, another_d;
   logic             thresh_wr_q, thresh_wr_d, seed_wr_q, seed_wr_d, err_q, err_d;

   logic       byte_v, is_hex, ack_new, fail;
   logic [3:0] nibble;
   logic [7:0] ack_chr;

   always_comb begin
      is_hex = 1'b1;
      nibble = 4'h0;
      if (rx_data >= "0" && rx_data <= "9")      nibble = 4'(rx_data - "0");
      else if (rx_data >= "a" && rx_data <= "f") nibble = 4'(rx_data - "a" + 8'd10);
      else if (rx_data >= "A" && rx_data <= "F") nibble = 4'(rx_data - "A" + 8'd10);
      else                                       is_hex = 1'b0;
   end

   // '\r' is invisible everywhere: it neither restarts the timer nor errors
   assign byte_v = rx_valid && (rx_data != 8'h0D);

   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      ndig_d       = ndig_q;
      timer_d      = timer_q;
      thresh_d     = thresh_q;
      seed_d       = seed_q;
      last_cmd_d   = last_cmd_q;
      soft_reset_d = 1'b0;
      another_d    = 1'b0;
      thresh_wr_d  = 1'b0;
      seed_wr_d    = 1'b0;
      ack_new      = 1'b0;
      ack_chr      = "K";
      fail         = 1'b0;
      case (state_q)
         IDLE: if (byte_v) begin
            case (rx_data)
               "r": begin soft_reset_d = 1'b1; ack_new = 1'b1; last_cmd_d = "r"; end
               "n": begin another_d = 1'b1; ack_new = 1'b1; last_cmd_d = "n"; end
               "t", "s": begin
                  state_d = (rx_data == "t") ? ARG_T : ARG_S;
                  acc_d   = '0;
                  ndig_d  = '0;
                  timer_d = '0;
               end
               8'h0A: ;
               default: fail = 1'b1;
            endcase
         end
         ARG_T, ARG_S: begin
            if (byte_v) begin
               timer_d = '0;
               if (is_hex) begin
                  if (ndig_q == ND_MAX) fail = 1'b1;
                  else begin
                     acc_d  = (acc_q << 4) | ARG_W'(nibble);
                     ndig_d = ndig_q + 1'b1;
                  end
               end else if (rx_data == 8'h0A && ndig_q != '0) begin
                  if (state_q == ARG_T) begin
                     thresh_d = acc_q; thresh_wr_d = 1'b1; last_cmd_d = "t";
                  end else begin
                     seed_d = acc_q; seed_wr_d = 1'b1; last_cmd_d = "s";
                  end
                  ack_new = 1'b1;
                  state_d = IDLE;
               end else begin
                  fail = 1'b1;
               end
            end else if (timer_q == TIMER_LAST) begin
               fail = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (fail) begin
         ack_new = 1'b1;
         ack_chr = "?";
         state_d = IDLE;
      end
      err_d = fail;
      // single-entry ack: a fresh ack always wins over a same-cycle drain
      ack_valid_d = ack_valid_q;
      ack_byte_d  = ack_byte_q;
      if (ack_new) begin
         ack_valid_d = 1'b1;
         ack_byte_d  = ack_chr;
      end else if (ack_ready && ack_valid_q) begin
         ack_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         acc_q        <= '0;
         ndig_q       <= '0;
         timer_q      <= '0;
         thresh_q     <= THRESH_RESET;
         seed_q       <= SEED_RESET;
         last_cmd_q   <= '0;
         ack_valid_q  <= 1'b0;
         ack_byte_q   <= '0;
         soft_reset_q <= 1'b0;
         another_q    <= 1'b0;
         thresh_wr_q  <= 1'b0;
         seed_wr_q    <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         ndig_q       <= ndig_d;
         timer_q      <= timer_d;
         thresh_q     <= thresh_d;
         seed_q       <= seed_d;
         last_cmd_q   <= last_cmd_d;
         ack_valid_q  <= ack_valid_d;
         ack_byte_q   <= ack_byte_d;
         soft_reset_q <= soft_reset_d;
         another_q    <= another_d;
         thresh_wr_q  <= thresh_wr_d;
         seed_wr_q    <= seed_wr_d;
         err_q        <= err_d;
      end
   end

   assign soft_reset = soft_reset_q;
   assign another    = another_q;
   assign thresh     = thresh_q;
   assign thresh_wr  = thresh_wr_q;
   assign seed       = seed_q;
   assign seed_wr    = seed_wr_q;
   assign err        = err_q;
   assign ack_valid  = ack_valid_q;
   assign ack_byte   = ack_byte_q;
   assign last_cmd   = last_cmd_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed scenarios then random byte traffic, all
// checked every cycle against a queue-based command interpreter.
module tb_uart_cmd_parser;
   localparam int          ARG_W  = 32;
   localparam int          TOUT   = 100;
   localparam logic [31:0] TH_RST = 32'd200000;
   localparam logic [31:0] SD_RST = 32'd1;

   logic        clk = 1'b0;
   logic        reset, rx_valid, ack_ready;
   logic [7:0]  rx_data;
   logic        soft_reset, another, thresh_wr, seed_wr, err, ack_valid;
   logic [31:0] thresh, seed;
   logic [7:0]  ack_byte, last_cmd;

   uart_cmd_parser #(.ARG_W(ARG_W), .THRESH_RESET(TH_RST), .SEED_RESET(SD_RST),
                     .TIMEOUT_CYC(TOUT)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .soft_reset(soft_reset), .another(another), .thresh(thresh), .thresh_wr(thresh_wr),
      .seed(seed), .seed_wr(seed_wr), .err(err), .ack_valid(ack_valid),
      .ack_byte(ack_byte), .ack_ready(ack_ready), .last_cmd(last_cmd));

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   logic rdy = 1'b1;

   // Reference: pending command letter plus the digits typed so far
   byte         m_mode;
   int          m_digits[$];
   int          m_since;
   logic [31:0] m_thresh, m_seed;
   logic [7:0]  m_last, m_ack_byte;
   logic        m_ack_valid;
   logic [4:0]  e_pulse;  // soft_reset, another, thresh_wr, seed_wr, err

   function automatic int hexval(input logic [7:0] c);
      if (c >= "0" && c <= "9") return int'(c) - 48;
      if (c >= "a" && c <= "f") return int'(c) - 87;
      if (c >= "A" && c <= "F") return int'(c) - 55;
      return -1;
   endfunction

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic rst, input logic v, input logic [7:0] d, input logic r);
      logic [7:0]  ack_new;
      logic        fail, in_arg, real_byte;
      logic [31:0] val;
      reset = rst; rx_valid = v; rx_data = d; ack_ready = r;
      e_pulse = '0; ack_new = 8'h00; fail = 1'b0;
      in_arg = (m_mode != 0);
      real_byte = v && (d != 8'h0D);
      if (rst) begin
         m_mode = 0; m_digits.delete(); m_since = 0;
         m_thresh = TH_RST; m_seed = SD_RST; m_last = 8'h00;
         m_ack_valid = 1'b0; m_ack_byte = 8'h00;
      end else begin
         if (in_arg) m_since++;
         if (real_byte && !in_arg) begin
            case (d)
               "r": begin e_pulse[4] = 1'b1; ack_new = "K"; m_last = "r"; end
               "n": begin e_pulse[3] = 1'b1; ack_new = "K"; m_last = "n"; end
               "t", "s": begin m_mode = byte'(d); m_digits.delete(); m_since = 0; end
               8'h0A: ;
               default: fail = 1'b1;
            endcase
         end else if (real_byte) begin
            m_since = 0;
            if (hexval(d) >= 0) begin
               if (m_digits.size() == ARG_W / 4) fail = 1'b1;
               else m_digits.push_back(hexval(d));
            end else if (d == 8'h0A && m_digits.size() > 0) begin
               val = 0;
               foreach (m_digits[i]) val = val * 16 + 32'(m_digits[i]);
               if (m_mode == "t") begin m_thresh = val; e_pulse[2] = 1'b1; end
               else begin m_seed = val; e_pulse[1] = 1'b1; end
               m_last = 8'(m_mode); ack_new = "K"; m_mode = 0;
            end else fail = 1'b1;
         end else if (in_arg && m_since == TOUT) begin
            fail = 1'b1;
         end
         if (fail) begin e_pulse[0] = 1'b1; ack_new = "?"; m_mode = 0; end
         if (ack_new != 8'h00) begin m_ack_valid = 1'b1; m_ack_byte = ack_new; end
         else if (r && m_ack_valid) m_ack_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      check("pulses", 96'({soft_reset, another, thresh_wr, seed_wr, err}), 96'(e_pulse));
      check("ack", 96'({ack_valid, ack_byte}), 96'({m_ack_valid, m_ack_byte}));
      check("regs", {thresh, seed, 24'h0, last_cmd}, {m_thresh, m_seed, 24'h0, m_last});
   endtask

   task automatic send(input logic [7:0] b);
      step(1'b0, 1'b1, b, rdy);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, rdy);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i]);
   endtask

   initial begin
      int   k;
      logic [7:0] b;
      string hexch;
      hexch = "0123456789abcdefABCDEF";
      // reset state
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b1);
      // T1 soft reset command
      send("r"); idle(2);
      // T2 threshold load
      send_str("t30D40\n"); idle(2);
      // T3 digit overflow on the ninth digit
      send_str("s123456789"); idle(2);
      // T4 empty argument and bad digit, then another
      send_str("t\n"); idle(1);
      send_str("t1g"); idle(1);
      send("n"); idle(1);
      // '\r' is ignored inside and outside arguments
      send_str("\rs\r5\r\n"); idle(1);
      // T5 timeout, then a byte exactly in the expiry cycle
      send_str("s12"); idle(TOUT + 3);
      send_str("s12"); idle(TOUT - 1); send("\n"); idle(2);
      // full-width argument
      send_str("tFFFFFFFF\n"); idle(1);
      // T6 ack overwrite while consumer stalled, then drain
      rdy = 1'b0;
      send("n"); send("x"); idle(2);
      rdy = 1'b1; idle(2);
      // new ack and drain in the same cycle
      rdy = 1'b0; send("r"); rdy = 1'b1; send("n"); idle(2);
      // reset mid-argument
      send_str("t12"); step(1'b1, 1'b0, 8'h00, 1'b1); send("\n"); send_str("34\n"); idle(2);

      // random traffic
      for (int n = 0; n < 1500; n++) begin
         rdy = ($urandom_range(0, 3) != 0);
         k = $urandom_range(0, 19);
         case (k)
            0: b = "r";  1: b = "n";  2, 3: b = "t";  4, 5: b = "s";
            6, 7: b = 8'h0A;  8: b = 8'h0D;  9: b = "x";  10: b = "g";
            default: b = hexch[$urandom_range(0, 21)];
         endcase
         if ($urandom_range(0, 299) == 0) step(1'b1, 1'b0, 8'h00, rdy);
         else if ($urandom_range(0, 59) == 0) idle(TOUT - 3 + $urandom_range(0, 6));
         else step(1'b0, ($urandom_range(0, 2) != 0), b, rdy);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
